reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Produces the 6502 core reset from the power-on reset and the board reset
// button. The button is synchronized into cpu_clk and debounced. The CPU
// reset is then held for a minimum time after every reset source clears.
// The module also reports the last reset cause and counts button resets.
//
// Ports:
//   cpu_clk    in   system/CPU clock, the only clock
//   ini_reset  in   asynchronous active-high initial reset
//   btn_reset  in   raw asynchronous board button (polarity set by BTN_ACTIVE_LOW)
//   reset      out  active-high CPU reset; asserts asynchronously, deasserts
//                   synchronously
//   reset_n    out  inverse of reset
//   btn_clean  out  debounced button, 1 = pressed
//   ready      out  one-cycle pulse on the edge where reset falls
//   rst_cause  out  last reset source: 01 initial, 10 button
//   rst_count  out  button-reset count, saturating at 255
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       cpu_clk,
  input  logic       ini_reset,
  input  logic       btn_reset,
  output logic       reset,
  output logic       reset_n,
  output logic       btn_clean,
  output logic       ready,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] CAUSE_INI = 2'b01;
  localparam logic [1:0] CAUSE_BTN = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_PRESSED
  } state_e;

  // Button normalised so that 1 always means "pressed".
  logic btn_norm;
  logic btn_s;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   btn_clean_q, btn_clean_d;
  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   reset_q, reset_d;
  logic                   ready_q, ready_d;
  logic [1:0]             rst_cause_q, rst_cause_d;
  logic [7:0]             rst_count_q, rst_count_d;
  logic [7:0]             rst_count_inc;

  assign btn_norm = BTN_ACTIVE_LOW ? ~btn_reset : btn_reset;
  assign btn_s    = sync_q[SYNC_STAGES-1];

  // Saturating increment: the count sticks at 255 instead of wrapping to 0.
  assign rst_count_inc = (rst_count_q == 8'hFF) ? rst_count_q : rst_count_q + 8'd1;

  // Synchronizer shift and debounce. The counter only advances while the
  // synchronized level disagrees with the accepted level. Any agreeing edge
  // restarts the count, so short pulses are dropped.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], btn_norm};
    db_cnt_d    = db_cnt_q;
    btn_clean_d = btn_clean_q;
    if (btn_s != btn_clean_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_clean_d = btn_s;
        db_cnt_d    = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Next-state logic.
  // PRESSED looks at the debouncer's next value. HOLD therefore starts on the
  // same edge where btn_clean falls. This puts the reset release HOLD_CYCLES
  // edges after the debounced release, the same spacing as at power-on.
  // HOLD will not release while the synchronized button still reads pressed,
  // even if that press has not yet been debounced.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rst_cause_d = rst_cause_q;
    rst_count_d = rst_count_q;
    ready_d     = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (btn_clean_q) begin
          state_d     = ST_PRESSED;
          rst_cause_d = CAUSE_BTN;
          rst_count_d = rst_count_inc;
        end else if (hold_cnt_q == HOLD_LAST) begin
          if (!btn_s) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (btn_clean_q) begin
          state_d     = ST_PRESSED;
          rst_cause_d = CAUSE_BTN;
          rst_count_d = rst_count_inc;
        end
      end
      ST_PRESSED: begin
        if (!btn_clean_d) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
    reset_d = (state_d != ST_RUN);
  end

  // State register. ini_reset clears everything at once, whatever state the
  // sequencer is in. reset is a flop, so it cannot glitch on a state decode.
  always_ff @(posedge cpu_clk or posedge ini_reset) begin
    if (ini_reset) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      btn_clean_q <= 1'b0;
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      reset_q     <= 1'b1;
      ready_q     <= 1'b0;
      rst_cause_q <= CAUSE_INI;
      rst_count_q <= '0;
    end else begin
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      btn_clean_q <= btn_clean_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      reset_q     <= reset_d;
      ready_q     <= ready_d;
      rst_cause_q <= rst_cause_d;
      rst_count_q <= rst_count_d;
    end
  end

  // Outputs.
  always_comb begin
    reset     = reset_q;
    reset_n   = ~reset_q;
    btn_clean = btn_clean_q;
    ready     = ready_q;
    rst_cause = rst_cause_q;
    rst_count = rst_count_q;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 16;
  localparam int HOLD_CYCLES     = 8;
  localparam bit BTN_ACTIVE_LOW  = 1'b1;

  logic       cpu_clk   = 1'b0;
  logic       ini_reset = 1'b1;
  logic       btn_reset = 1'b1;
  logic       reset;
  logic       reset_n;
  logic       btn_clean;
  logic       ready;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  int checks   = 0;
  int failures = 0;

  reset_sequencer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) dut (
    .cpu_clk  (cpu_clk),
    .ini_reset(ini_reset),
    .btn_reset(btn_reset),
    .reset    (reset),
    .reset_n  (reset_n),
    .btn_clean(btn_clean),
    .ready    (ready),
    .rst_cause(rst_cause),
    .rst_count(rst_count)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Reference model. The synchronizer is a delay queue of raw samples.
  // Debounce is the length of the current run of disagreeing samples.
  // The hold time is a countdown of edges left before release.
  bit m_pipe[$];
  int m_run;
  bit m_clean;
  bit m_rst;
  bit m_pressed;
  int m_left;
  bit m_ready;
  int m_cause;
  int m_count;

  task automatic modelReset();
    m_pipe.delete();
    repeat (SYNC_STAGES) m_pipe.push_back(1'b0);
    m_run     = 0;
    m_clean   = 1'b0;
    m_rst     = 1'b1;
    m_pressed = 1'b0;
    m_left    = HOLD_CYCLES;
    m_ready   = 1'b0;
    m_cause   = 1;
    m_count   = 0;
  endtask

  task automatic modelEdge(input bit raw);
    bit s;
    bit old_clean;
    s = m_pipe.pop_front();
    m_pipe.push_back(raw);
    old_clean = m_clean;
    if (s != m_clean) begin
      m_run++;
      if (m_run == DEBOUNCE_CYCLES) begin
        m_clean = s;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_ready = 1'b0;
    if (!m_rst) begin
      if (old_clean) begin
        m_rst     = 1'b1;
        m_pressed = 1'b1;
        m_cause   = 2;
        m_count   = (m_count < 255) ? m_count + 1 : 255;
      end
    end else if (m_pressed) begin
      if (!m_clean) begin
        m_pressed = 1'b0;
        m_left    = HOLD_CYCLES;
      end
    end else if (old_clean) begin
      m_pressed = 1'b1;
      m_cause   = 2;
      m_count   = (m_count < 255) ? m_count + 1 : 255;
    end else begin
      if (m_left > 0) m_left--;
      if (m_left == 0 && !s) begin
        m_rst   = 1'b0;
        m_ready = 1'b1;
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue($sformatf("%s reset", tag), {7'd0, reset}, {7'd0, m_rst});
    checkValue($sformatf("%s reset_n", tag), {7'd0, reset_n}, {7'd0, ~m_rst});
    checkValue($sformatf("%s btn_clean", tag), {7'd0, btn_clean}, {7'd0, m_clean});
    checkValue($sformatf("%s ready", tag), {7'd0, ready}, {7'd0, m_ready});
    checkValue($sformatf("%s rst_cause", tag), {6'd0, rst_cause}, 8'(m_cause));
    checkValue($sformatf("%s rst_count", tag), rst_count, 8'(m_count));
  endtask

  // Drives one cycle of inputs just after a falling edge. The model steps on
  // the rising edge, and the outputs are compared on the next falling edge.
  task automatic applyStimulus(input bit raw, input bit ini, input string tag);
    btn_reset = BTN_ACTIVE_LOW ? ~raw : raw;
    ini_reset = ini;
    if (ini) modelReset();
    @(posedge cpu_clk);
    if (!ini) modelEdge(raw);
    @(negedge cpu_clk);
    checkOutput(tag);
  endtask

  task automatic holdLevel(input bit raw, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(raw, 1'b0, tag);
  endtask

  typedef struct {
    bit         ini;
    bit         raw;
    bit         exp_reset;
    bit         exp_ready;
    bit         exp_clean;
    logic [1:0] exp_cause;
    logic [7:0] exp_count;
  } vec_t;

  vec_t pwr[15];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Power-on table: five cycles of ini_reset, then count edges from release.
    for (int i = 0; i < 15; i++) begin
      pwr[i].ini       = (i < 5);
      pwr[i].raw       = 1'b0;
      pwr[i].exp_reset = (i < 5) || ((i - 4) < HOLD_CYCLES);
      pwr[i].exp_ready = (i >= 5) && ((i - 4) == HOLD_CYCLES);
      pwr[i].exp_clean = 1'b0;
      pwr[i].exp_cause = 2'b01;
      pwr[i].exp_count = 8'd0;
    end

    modelReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(pwr[i].raw, pwr[i].ini, "powerOn");
      checkValue($sformatf("pwr[%0d] reset", i), {7'd0, reset}, {7'd0, pwr[i].exp_reset});
      checkValue($sformatf("pwr[%0d] reset_n", i), {7'd0, reset_n}, {7'd0, ~pwr[i].exp_reset});
      checkValue($sformatf("pwr[%0d] ready", i), {7'd0, ready}, {7'd0, pwr[i].exp_ready});
      checkValue($sformatf("pwr[%0d] btn_clean", i), {7'd0, btn_clean}, {7'd0, pwr[i].exp_clean});
      checkValue($sformatf("pwr[%0d] rst_cause", i), {6'd0, rst_cause}, {6'd0, pwr[i].exp_cause});
      checkValue($sformatf("pwr[%0d] rst_count", i), rst_count, pwr[i].exp_count);
    end

    // A 10-cycle glitch is shorter than the debounce window.
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(k <= 10, 1'b0, "glitch");
      checkValue("glitch btn_clean", {7'd0, btn_clean}, 8'd0);
      checkValue("glitch reset", {7'd0, reset}, 8'd0);
    end
    checkValue("glitch rst_count", rst_count, 8'd0);

    // Full press: reset rises on edge 19 after the raw press.
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, 1'b0, "press");
      if (k == 17) checkValue("press btn_clean@17", {7'd0, btn_clean}, 8'd0);
      if (k == 18) checkValue("press btn_clean@18", {7'd0, btn_clean}, 8'd1);
      if (k == 18) checkValue("press reset@18", {7'd0, reset}, 8'd0);
      if (k == 19) checkValue("press reset@19", {7'd0, reset}, 8'd1);
    end
    checkValue("press rst_cause", {6'd0, rst_cause}, 8'd2);
    checkValue("press rst_count", rst_count, 8'd1);

    // Release: btn_clean falls on edge 18, reset falls 8 edges later.
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, "release");
      if (k == 17) checkValue("release btn_clean@17", {7'd0, btn_clean}, 8'd1);
      if (k == 18) checkValue("release btn_clean@18", {7'd0, btn_clean}, 8'd0);
      if (k == 25) checkValue("release reset@25", {7'd0, reset}, 8'd1);
      if (k == 25) checkValue("release ready@25", {7'd0, ready}, 8'd0);
      if (k == 26) checkValue("release reset@26", {7'd0, reset}, 8'd0);
      if (k == 26) checkValue("release ready@26", {7'd0, ready}, 8'd1);
      if (k == 27) checkValue("release ready@27", {7'd0, ready}, 8'd0);
    end

    // Reach PRESSED with a count of 3, then hit ini_reset between edges.
    holdLevel(1'b1, 20, "press2");
    holdLevel(1'b0, 30, "release2");
    holdLevel(1'b1, 20, "press3");
    checkValue("press3 rst_count", rst_count, 8'd3);
    ini_reset = 1'b1;
    #1;
    checkValue("midop reset", {7'd0, reset}, 8'd1);
    checkValue("midop reset_n", {7'd0, reset_n}, 8'd0);
    checkValue("midop btn_clean", {7'd0, btn_clean}, 8'd0);
    checkValue("midop rst_count", rst_count, 8'd0);
    checkValue("midop rst_cause", {6'd0, rst_cause}, 8'd1);
    checkValue("midop ready", {7'd0, ready}, 8'd0);
    modelReset();

    // Button held across the ini_reset release: reset never drops.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, "heldIni");
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, 1'b0, "held");
      checkValue("held reset", {7'd0, reset}, 8'd1);
    end
    checkValue("held rst_count", rst_count, 8'd1);
    checkValue("held rst_cause", {6'd0, rst_cause}, 8'd2);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, "heldRelease");
      if (k < 26) checkValue("heldRelease reset", {7'd0, reset}, 8'd1);
      if (k == 18) checkValue("heldRelease btn_clean@18", {7'd0, btn_clean}, 8'd0);
      if (k == 26) checkValue("heldRelease reset@26", {7'd0, reset}, 8'd0);
    end

    // Saturation: start from a fresh reset and run 260 presses.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, "satIni");
    holdLevel(1'b0, 12, "satBoot");
    for (int p = 1; p <= 260; p++) begin
      holdLevel(1'b1, 20, "satPress");
      checkValue($sformatf("sat rst_count press %0d", p), rst_count, 8'((p < 255) ? p : 255));
      holdLevel(1'b0, 27, "satRelease");
    end

    // Random segments of button levels with occasional ini_reset bursts.
    begin
      int cyc;
      cyc = 0;
      while (cyc < 3000) begin
        if ($urandom_range(0, 19) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b1, "randIni");
          cyc += len;
        end else begin
          int len;
          bit lvl;
          len = $urandom_range(1, 45);
          lvl = 1'($urandom_range(0, 1));
          holdLevel(lvl, len, "rand");
          cyc += len;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
